// File: rtl/rgb_fade_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rgb_fade_sequencer_pkg : shared types, constants and step helper
// Rev 1.0
// ---------------------------------------------------------------------------
package rgb_fade_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_COMMIT = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  localparam int CH_R        = 0;
  localparam int CH_G        = 1;
  localparam int CH_B        = 2;
  localparam int NUM_CH      = 3;
  localparam int LEVEL_W     = 8;
  localparam int LUT_ADDR_W  = 8;
  localparam int LUT_LATENCY = 1;

  function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                     input logic [LEVEL_W-1:0] tgt);
    if (cur < tgt)      return cur + LEVEL_W'(1);
    else if (cur > tgt) return cur - LEVEL_W'(1);
    else                return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fade_sequencer_pwm_compare.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rgb_fade_sequencer_pwm_compare : registered (cnt < duty) LED output
// Rev 1.0
// ---------------------------------------------------------------------------
module rgb_fade_sequencer_pwm_compare #(
  parameter int PWM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                led_o
);

  logic led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 1'b0;
    else        led_q <= enable_i && (cnt_i < duty_i);
  end

  assign led_o = led_q;

endmodule
`default_nettype wire

// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rgb_fade_sequencer : RGB fade stepping, shared gamma LUT, frame-synced PWM
// Rev 1.0
// ---------------------------------------------------------------------------
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int PWM_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [23:0]           target_rgb_i,
  input  logic [15:0]           step_period_i,
  input  logic                  target_valid_i,
  output logic                  target_ready_o,
  output logic                  lut_rd_o,
  output logic [LUT_ADDR_W-1:0] lut_addr_o,
  input  logic [15:0]           lut_data_i,
  output logic [PWM_BITS-1:0]   duty_r_o,
  output logic [PWM_BITS-1:0]   duty_g_o,
  output logic [PWM_BITS-1:0]   duty_b_o,
  output logic                  frame_start_o,
  output logic                  led_r_o,
  output logic                  led_g_o,
  output logic                  led_b_o,
  output logic                  busy_o
);

  state_e state_q, state_d;
  logic [NUM_CH-1:0][LEVEL_W-1:0]  cur_q, cur_d, tgt_q, tgt_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0] shadow_q, duty_q, duty_d;
  logic [15:0]         period_q, period_d, wait_q, wait_d;
  logic [1:0]          lk_q, lk_d, rd_ch_q;
  logic                first_q, first_d, rd_vld_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic                fs_q;
  logic [NUM_CH-1:0]   led_w;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    period_d   = period_q;
    wait_d     = wait_q;
    lk_d       = lk_q;
    first_d    = first_q;
    duty_d     = duty_q;
    lut_rd_o   = 1'b0;
    lut_addr_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (target_valid_i) begin
          tgt_d[CH_R] = target_rgb_i[23:16];
          tgt_d[CH_G] = target_rgb_i[15:8];
          tgt_d[CH_B] = target_rgb_i[7:0];
          period_d    = (step_period_i == 16'd0) ? 16'd1 : step_period_i;
          first_d     = 1'b1;
          state_d     = ST_STEP;
        end
      end
      ST_STEP: begin
        // The pass right after accept looks up the unchanged levels, so a
        // fade of N levels takes N+1 commits and equal targets still commit.
        if (enable_i) begin
          if (!first_q) begin
            for (int c = 0; c < NUM_CH; c++) cur_d[c] = step_toward(cur_q[c], tgt_q[c]);
          end
          first_d = 1'b0;
          lk_d    = 2'd0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (enable_i) begin
          if (lk_q != 2'd3) begin
            lut_rd_o = 1'b1;
            case (lk_q)
              2'd0:    lut_addr_o = cur_q[CH_R];
              2'd1:    lut_addr_o = cur_q[CH_G];
              default: lut_addr_o = cur_q[CH_B];
            endcase
            lk_d = lk_q + 2'd1;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        if (fs_q) begin
          duty_d  = shadow_q;
          wait_d  = 16'd1;  // the commit frame counts as the first waited frame
          state_d = (cur_q == tgt_q) ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (enable_i) begin
          if (wait_q >= period_q) state_d = ST_STEP;
          else if (fs_q)          wait_d  = wait_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      tgt_q    <= '0;
      period_q <= 16'd1;
      wait_q   <= '0;
      lk_q     <= '0;
      first_q  <= 1'b0;
      duty_q   <= '0;
      shadow_q <= '0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      cnt_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      period_q <= period_d;
      wait_q   <= wait_d;
      lk_q     <= lk_d;
      first_q  <= first_d;
      duty_q   <= duty_d;
      rd_vld_q <= lut_rd_o;
      rd_ch_q  <= lk_q;
      cnt_q    <= enable_i ? cnt_q + PWM_BITS'(1) : '0;
      fs_q     <= enable_i && (cnt_q == {PWM_BITS{1'b1}});
      // Capture runs off the delayed strobe so data is never lost if
      // enable drops while a read is in flight.
      if (rd_vld_q) begin
        case (rd_ch_q)
          2'd0:    shadow_q[CH_R] <= lut_data_i[15 -: PWM_BITS];
          2'd1:    shadow_q[CH_G] <= lut_data_i[15 -: PWM_BITS];
          default: shadow_q[CH_B] <= lut_data_i[15 -: PWM_BITS];
        endcase
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pwm
      rgb_fade_sequencer_pwm_compare #(.PWM_BITS(PWM_BITS)) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable_i),
        .cnt_i    (cnt_q),
        .duty_i   (duty_q[c]),
        .led_o    (led_w[c])
      );
    end
  endgenerate

  assign target_ready_o = rst_n && (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign frame_start_o  = fs_q;
  assign duty_r_o       = duty_q[CH_R];
  assign duty_g_o       = duty_q[CH_G];
  assign duty_b_o       = duty_q[CH_B];
  assign led_r_o        = led_w[CH_R];
  assign led_g_o        = led_w[CH_G];
  assign led_b_o        = led_w[CH_B];

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rgb_fade_sequencer : directed fades against a frame-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] target_rgb = '0;
  logic [15:0] step_period = '0;
  logic        target_valid = 1'b0;
  logic        target_ready, lut_rd, frame_start, led_r, led_g, led_b, busy;
  logic [7:0]  lut_addr, duty_r, duty_g, duty_b;
  logic [15:0] lut_data;

  rgb_fade_sequencer #(.PWM_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .target_rgb_i(target_rgb),
    .step_period_i(step_period), .target_valid_i(target_valid),
    .target_ready_o(target_ready), .lut_rd_o(lut_rd), .lut_addr_o(lut_addr),
    .lut_data_i(lut_data), .duty_r_o(duty_r), .duty_g_o(duty_g), .duty_b_o(duty_b),
    .frame_start_o(frame_start), .led_r_o(led_r), .led_g_o(led_g), .led_b_o(led_b),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Identity gamma LUT: data = addr * 256, one cycle read latency.
  always @(posedge clk) lut_data <= lut_rd ? {lut_addr, 8'h00} : 16'hDEAD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame counting, commit schedule and per-commit levels.
  int m_cnt, m_duty[3], m_cur[3], m_start[3], m_tgt[3];
  bit m_fs, m_active, m_first, fs_now;
  bit m_led[3];
  int m_since, m_left, m_k, m_kmax, m_P, m_commits;

  function automatic int lvl(input int k, input int c);
    int d, ad, s;
    d  = m_tgt[c] - m_start[c];
    ad = (d < 0) ? -d : d;
    s  = (k < ad) ? k : ad;
    return (d >= 0) ? m_start[c] + s : m_start[c] - s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_fs = 0; m_active = 0; m_first = 0; m_commits = 0;
      m_since = 0; m_left = 0; m_k = 0; m_kmax = 0; m_P = 1;
      for (int c = 0; c < 3; c++) begin
        m_duty[c] = 0; m_cur[c] = 0; m_led[c] = 0; m_start[c] = 0; m_tgt[c] = 0;
      end
    end else begin
      fs_now = m_fs;
      for (int c = 0; c < 3; c++) m_led[c] = enable && (m_cnt < m_duty[c]);
      m_fs  = enable && (m_cnt == 255);
      m_cnt = enable ? (m_cnt + 1) % 256 : 0;
      if (m_active) begin
        if (fs_now && ((m_first && m_since >= 5) || (!m_first && m_left == 1))) begin
          for (int c = 0; c < 3; c++) begin
            m_cur[c]  = lvl(m_k, c);
            m_duty[c] = m_cur[c];
          end
          m_k++; m_commits++; m_first = 0; m_left = m_P;
          if (m_k > m_kmax) m_active = 0;
        end else if (fs_now && !m_first) begin
          m_left--;
        end
        if (enable) m_since++;
      end else if (target_valid) begin
        m_active = 1; m_first = 1; m_since = 0; m_k = 0; m_kmax = 0;
        m_P = (step_period == 0) ? 1 : int'(step_period);
        m_tgt[0] = target_rgb[23:16]; m_tgt[1] = target_rgb[15:8]; m_tgt[2] = target_rgb[7:0];
        for (int c = 0; c < 3; c++) begin
          m_start[c] = m_cur[c];
          if (m_tgt[c] - m_cur[c] > m_kmax) m_kmax = m_tgt[c] - m_cur[c];
          if (m_cur[c] - m_tgt[c] > m_kmax) m_kmax = m_cur[c] - m_tgt[c];
        end
      end
    end
  end

  int rd_idx = 0;
  int rd_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      check("frame_start", frame_start, m_fs);
      check("led_r", led_r, m_led[0]);
      check("led_g", led_g, m_led[1]);
      check("led_b", led_b, m_led[2]);
      check("duty_r", duty_r, m_duty[0]);
      check("duty_g", duty_g, m_duty[1]);
      check("duty_b", duty_b, m_duty[2]);
      check("busy", busy, m_active);
      check("target_ready", target_ready, !m_active);
      if (lut_rd) begin
        check("lut_rd_while_idle", 1, m_active);
        check("lut_addr", lut_addr, lvl(m_k, rd_idx));
        rd_idx = (rd_idx + 1) % 3;
        rd_cnt++;
      end
    end else begin
      rd_idx = 0;
      rd_cnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; enable = 1'b0; target_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic accept(input logic [23:0] rgb, input logic [15:0] per);
    target_rgb = rgb; step_period = per; target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_duty_b(input int val, input int max, output int t);
    int n;
    n = 0;
    while (duty_b != val && n < max) begin @(negedge clk); n++; end
    check("duty_b_timeout", duty_b, val);
    t = cyc;
  endtask

  int t1, t2, fs_seen, led_seen, n;

  initial begin
    // Fade 0 -> 0x102030, one frame per step, with an ignored mid-fade offer.
    do_reset();
    check("reset_ready", target_ready, 1);
    check("reset_duty_r", duty_r, 0);
    accept(24'h102030, 16'd1);
    repeat (20 * 256) @(negedge clk);
    target_rgb = 24'hFFFFFF; target_valid = 1'b1;
    check("busy_ready_low", target_ready, 0);
    repeat (5) @(negedge clk);
    target_valid = 1'b0;
    wait_idle(60 * 256);
    check("fade_r", duty_r, 8'h10);
    check("fade_g", duty_g, 8'h20);
    check("fade_b", duty_b, 8'h30);
    check("fade_commits", m_commits, 49);
    check("fade_lut_reads", rd_cnt, 147);

    // Equal target from reset: one lookup of LUT[0], then idle.
    do_reset();
    accept(24'h000000, 16'd1);
    wait_idle(600);
    check("zero_commits", m_commits, 1);
    check("zero_lut_reads", rd_cnt, 3);
    check("zero_duty_g", duty_g, 0);

    // step_period 0 and 1 both give one-frame commit spacing.
    do_reset();
    accept(24'h000003, 16'd0);
    wait_duty_b(1, 1200, t1);
    wait_duty_b(2, 600, t2);
    check("spacing_p0", t2 - t1, 256);
    wait_idle(1200);
    do_reset();
    accept(24'h000003, 16'd1);
    wait_duty_b(1, 1200, t1);
    wait_duty_b(2, 600, t2);
    check("spacing_p1", t2 - t1, 256);
    wait_idle(1200);

    // enable low for 300 cycles while waiting between steps.
    do_reset();
    accept(24'h000004, 16'd2);
    wait_duty_b(1, 2000, t1);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    fs_seen = 0; led_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      fs_seen  += int'(frame_start);
      led_seen += int'(led_r | led_g | led_b);
    end
    check("disabled_frame_start", fs_seen, 0);
    check("disabled_leds", led_seen, 0);
    check("disabled_busy", busy, 1);
    enable = 1'b1;
    wait_idle(10 * 256);
    check("enable_commits", m_commits, 5);
    check("enable_duty_b", duty_b, 4);

    // Asynchronous reset while a lookup is in progress.
    do_reset();
    accept(24'h050505, 16'd1);
    n = 0;
    while (!lut_rd && n < 20) begin @(negedge clk); n++; end
    check("lookup_seen", lut_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", target_ready, 0);
    check("arst_lut_rd", lut_rd, 0);
    check("arst_leds", {led_r, led_g, led_b}, 0);
    check("arst_duties", {duty_r, duty_g, duty_b}, 0);
    check("arst_fs", frame_start, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    check("release_ready", target_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
